// File: rtl/seq_alu.sv
// seq_alu: registered, valid/ready-handshaked ALU holding the NZCV flag register,
// with carry-chained add/sub, shifts with carry-out and an iterative shift-add MUL.
module seq_alu #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       uop,
    input  logic [WIDTH-1:0] lhs,
    input  logic [WIDTH-1:0] rhs,
    input  logic             set_flags,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_wb,
    output logic [3:0]       flags,
    output logic             busy
);
    localparam int MSB   = WIDTH - 1;
    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [4:0] OP_ADD  = 5'd1;
    localparam logic [4:0] OP_SUB  = 5'd2;
    localparam logic [4:0] OP_AND  = 5'd3;
    localparam logic [4:0] OP_EOR  = 5'd4;
    localparam logic [4:0] OP_CMP  = 5'd5;
    localparam logic [4:0] OP_LSL  = 5'd6;
    localparam logic [4:0] OP_LSR  = 5'd7;
    localparam logic [4:0] OP_MOV  = 5'd8;
    localparam logic [4:0] OP_ADC  = 5'd9;
    localparam logic [4:0] OP_SBC  = 5'd10;
    localparam logic [4:0] OP_ASR  = 5'd11;
    localparam logic [4:0] OP_MUL  = 5'd12;
    localparam logic [4:0] OP_ADDR = 5'd13;

    typedef enum logic {IDLE, MUL_RUN} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic               mul_sf_q, mul_sf_d;
    logic               out_valid_q, out_valid_d;
    logic               out_wb_q, out_wb_d;
    logic [WIDTH-1:0]   out_result_q, out_result_d;
    logic [3:0]         flags_q, flags_d;

    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH-1:0]   addend;
    logic               cin;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     lsl_ext;
    logic [WIDTH:0]     lsr_ext;
    logic signed [WIDTH:0] asr_ext;
    logic [WIDTH-1:0]   alu_res;
    logic [WIDTH-1:0]   acc_next;
    logic               alu_wb, alu_can_set, alu_c, alu_v;
    logic               accept, can_complete;

    // Shifts carry one extra bit so the last bit shifted out lands in a fixed position.
    assign shamt   = rhs[SHAMT_W-1:0];
    assign lsl_ext = {1'b0, lhs} << shamt;
    assign lsr_ext = {lhs, 1'b0} >> shamt;
    assign asr_ext = $signed({lhs, 1'b0}) >>> shamt;

    always_comb begin
        addend = rhs;
        cin    = 1'b0;
        case (uop)
            OP_SUB, OP_CMP: begin
                addend = ~rhs;
                cin    = 1'b1;
            end
            OP_SBC: begin
                addend = ~rhs;
                cin    = flags_q[1];
            end
            OP_ADC:  cin = flags_q[1];
            default: ;
        endcase
        sum = {1'b0, lhs} + {1'b0, addend} + {{WIDTH{1'b0}}, cin};

        alu_res     = '0;
        alu_wb      = 1'b1;
        alu_can_set = 1'b1;
        alu_c       = flags_q[1];
        alu_v       = flags_q[0];
        case (uop)
            OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_CMP: begin
                alu_res = sum[MSB:0];
                alu_c   = sum[WIDTH];
                alu_v   = (lhs[MSB] == addend[MSB]) && (sum[MSB] != lhs[MSB]);
                alu_wb  = (uop != OP_CMP);
            end
            OP_AND: alu_res = lhs & rhs;
            OP_EOR: alu_res = lhs ^ rhs;
            OP_MOV: alu_res = rhs;
            OP_LSL: begin
                alu_res = lhs;
                if (shamt != '0) begin
                    alu_res = lsl_ext[MSB:0];
                    alu_c   = lsl_ext[WIDTH];
                end
            end
            OP_LSR: begin
                alu_res = lhs;
                if (shamt != '0) begin
                    alu_res = lsr_ext[WIDTH:1];
                    alu_c   = lsr_ext[0];
                end
            end
            OP_ASR: begin
                alu_res = lhs;
                if (shamt != '0) begin
                    alu_res = asr_ext[WIDTH:1];
                    alu_c   = asr_ext[0];
                end
            end
            OP_ADDR: begin
                alu_res     = lhs + rhs;
                alu_can_set = 1'b0;
            end
            default: begin
                alu_wb      = 1'b0;
                alu_can_set = 1'b0;
            end
        endcase
    end

    // The final multiplier step and the result write share one edge to hit WIDTH+1 latency.
    assign can_complete = !out_valid_q || out_ready;
    assign accept       = in_valid && in_ready;
    assign acc_next     = (cnt_q != '0 && mplier_q[0]) ? acc_q + mcand_q : acc_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        mcand_d      = mcand_q;
        mplier_d     = mplier_q;
        acc_d        = acc_q;
        mul_sf_d     = mul_sf_q;
        out_valid_d  = out_valid_q;
        out_wb_d     = out_wb_q;
        out_result_d = out_result_q;
        flags_d      = flags_q;
        in_ready     = (state_q == IDLE) && can_complete;

        if (out_valid_q && out_ready)
            out_valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (uop == OP_MUL) begin
                        state_d  = MUL_RUN;
                        cnt_d    = CNT_W'(WIDTH);
                        mcand_d  = lhs;
                        mplier_d = rhs;
                        acc_d    = '0;
                        mul_sf_d = set_flags;
                    end else begin
                        out_valid_d  = 1'b1;
                        out_result_d = alu_res;
                        out_wb_d     = alu_wb;
                        if (alu_can_set && (set_flags || uop == OP_CMP))
                            flags_d = {alu_res[MSB], alu_res == '0, alu_c, alu_v};
                    end
                end
            end
            MUL_RUN: begin
                if (cnt_q != '0) begin
                    acc_d    = acc_next;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q - CNT_W'(1);
                end
                if (cnt_q <= CNT_W'(1) && can_complete) begin
                    state_d      = IDLE;
                    out_valid_d  = 1'b1;
                    out_result_d = acc_next;
                    out_wb_d     = 1'b1;
                    if (mul_sf_q)
                        flags_d = {acc_next[MSB], acc_next == '0, flags_q[1:0]};
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            mcand_q      <= '0;
            mplier_q     <= '0;
            acc_q        <= '0;
            mul_sf_q     <= 1'b0;
            out_valid_q  <= 1'b0;
            out_wb_q     <= 1'b0;
            out_result_q <= '0;
            flags_q      <= 4'b0000;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            mcand_q      <= mcand_d;
            mplier_q     <= mplier_d;
            acc_q        <= acc_d;
            mul_sf_q     <= mul_sf_d;
            out_valid_q  <= out_valid_d;
            out_wb_q     <= out_wb_d;
            out_result_q <= out_result_d;
            flags_q      <= flags_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_wb     = out_wb_q;
    assign flags      = flags_q;
    assign busy       = (state_q == MUL_RUN);
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed and randomized checks of seq_alu against an arithmetic
// reference model of results, write-back and NZCV flags.
module tb_seq_alu;
    localparam int WIDTH = 32;

    logic             clk, rst_n, in_valid, in_ready, set_flags;
    logic             out_valid, out_ready, out_wb, busy;
    logic [4:0]       uop;
    logic [WIDTH-1:0] lhs, rhs, out_result;
    logic [3:0]       flags;

    int               compared;
    int               mismatched;
    logic [3:0]       modelFlags;

    seq_alu #(.WIDTH(WIDTH), .SHAMT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .uop(uop), .lhs(lhs), .rhs(rhs), .set_flags(set_flags),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_wb(out_wb), .flags(flags), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: signed overflow is detected as "exact signed result does not fit".
    function automatic void model(input logic [4:0] u, input logic [31:0] a, input logic [31:0] b,
                                  input logic sf, output logic [31:0] r, output logic wb);
        longint     sa, sb, sr;
        logic [63:0] wide;
        int         s;
        logic       c, v, canSet, carryIn, borrow;
        c      = modelFlags[1];
        v      = modelFlags[0];
        r      = 32'd0;
        wb     = 1'b1;
        canSet = 1'b1;
        sa     = longint'($signed(a));
        sb     = longint'($signed(b));
        s      = int'(b[7:0]);
        case (u)
            5'd1, 5'd9: begin
                carryIn = (u == 5'd9) ? modelFlags[1] : 1'b0;
                wide = 64'(a) + 64'(b) + 64'(carryIn);
                r    = wide[31:0];
                c    = wide[32];
                sr   = sa + sb + longint'(carryIn);
                v    = (sr != longint'($signed(r)));
            end
            5'd2, 5'd5, 5'd10: begin
                borrow = (u == 5'd10) ? !modelFlags[1] : 1'b0;
                r  = a - b - 32'(borrow);
                c  = (64'(a) >= 64'(b) + 64'(borrow));
                sr = sa - sb - longint'(borrow);
                v  = (sr != longint'($signed(r)));
                wb = (u != 5'd5);
            end
            5'd3: r = a & b;
            5'd4: r = a ^ b;
            5'd8: r = b;
            5'd6: begin
                r = a;
                if (s != 0) begin
                    r = (s >= 32) ? 32'd0 : a << s;
                    c = (s <= 32) ? a[32 - s] : 1'b0;
                end
            end
            5'd7: begin
                r = a;
                if (s != 0) begin
                    r = a >> s;
                    c = (s <= 32) ? a[s - 1] : 1'b0;
                end
            end
            5'd11: begin
                r = a;
                if (s != 0) begin
                    r = 32'($signed(a) >>> s);
                    c = (s <= 32) ? a[s - 1] : a[31];
                end
            end
            5'd12: begin
                wide = 64'(a) * 64'(b);
                r    = wide[31:0];
            end
            5'd13: begin
                r      = a + b;
                canSet = 1'b0;
            end
            default: begin
                wb     = 1'b0;
                canSet = 1'b0;
            end
        endcase
        if (canSet && (sf || u == 5'd5))
            modelFlags = {r[31], r == 32'd0, c, v};
    endfunction

    // Presents one request, waits for acceptance, then waits for the result beat.
    task automatic do_op(input logic [4:0] u, input logic [31:0] a, input logic [31:0] b,
                         input logic sf, output int lat);
        int n;
        uop = u; lhs = a; rhs = b; set_flags = sf; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        uop = 5'd0; lhs = '0; rhs = '0; set_flags = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        modelFlags = 4'b0000;
        compared++; if (out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_out_valid: got %b expected 0", out_valid); end
        compared++; if (out_result !== 32'd0) begin mismatched++; $display("[TB] FAIL rst_out_result: got %h expected 0", out_result); end
        compared++; if (out_wb !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_out_wb: got %b expected 0", out_wb); end
        compared++; if (flags !== 4'b0000) begin mismatched++; $display("[TB] FAIL rst_flags: got %b expected 0000", flags); end
        compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_busy: got %b expected 0", busy); end
        compared++; if (in_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL rst_in_ready: got %b expected 1", in_ready); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_mul();
        logic [31:0] expRes;
        logic        expWb;
        int          lat, beats;
        model(5'd1, 32'hFFFF_FFFF, 32'd1, 1'b1, expRes, expWb);
        do_op(5'd1, 32'hFFFF_FFFF, 32'd1, 1'b1, lat);
        compared++; if (flags !== modelFlags) begin mismatched++; $display("[TB] FAIL pre_mul_flags: got %b expected %b", flags, modelFlags); end
        uop = 5'd12; lhs = 32'd7; rhs = 32'd9; set_flags = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        modelFlags = 4'b0000;
        compared++; if (out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL midmul_out_valid: got %b expected 0", out_valid); end
        compared++; if (flags !== 4'b0000) begin mismatched++; $display("[TB] FAIL midmul_flags: got %b expected 0000", flags); end
        compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL midmul_busy: got %b expected 0", busy); end
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        compared++; if (in_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL midmul_in_ready: got %b expected 1", in_ready); end
        beats = 0;
        repeat (40) begin
            if (out_valid) beats++;
            @(posedge clk); #1;
        end
        compared++; if (beats !== 0) begin mismatched++; $display("[TB] FAIL midmul_beats: got %0d expected 0", beats); end
    endtask

    task automatic test_add_adc();
        logic [31:0] expRes;
        logic        expWb;
        int          lat;
        model(5'd1, 32'hFFFF_FFFF, 32'd1, 1'b1, expRes, expWb);
        do_op(5'd1, 32'hFFFF_FFFF, 32'd1, 1'b1, lat);
        compared++; if (lat !== 1) begin mismatched++; $display("[TB] FAIL add_latency: got %0d expected 1", lat); end
        compared++; if (out_result !== 32'd0) begin mismatched++; $display("[TB] FAIL add_result: got %h expected 0", out_result); end
        compared++; if (flags !== 4'b0110) begin mismatched++; $display("[TB] FAIL add_flags: got %b expected 0110", flags); end
        model(5'd9, 32'd5, 32'd3, 1'b0, expRes, expWb);
        do_op(5'd9, 32'd5, 32'd3, 1'b0, lat);
        compared++; if (out_result !== 32'd9) begin mismatched++; $display("[TB] FAIL adc_result: got %h expected 9", out_result); end
        compared++; if (out_wb !== 1'b1) begin mismatched++; $display("[TB] FAIL adc_wb: got %b expected 1", out_wb); end
    endtask

    task automatic test_cmp();
        logic [31:0] expRes;
        logic        expWb;
        int          lat;
        model(5'd5, 32'h8000_0000, 32'd1, 1'b0, expRes, expWb);
        do_op(5'd5, 32'h8000_0000, 32'd1, 1'b0, lat);
        compared++; if (out_result !== 32'h7FFF_FFFF) begin mismatched++; $display("[TB] FAIL cmp_result: got %h expected 7fffffff", out_result); end
        compared++; if (out_wb !== 1'b0) begin mismatched++; $display("[TB] FAIL cmp_wb: got %b expected 0", out_wb); end
        compared++; if (flags !== 4'b0011) begin mismatched++; $display("[TB] FAIL cmp_flags: got %b expected 0011", flags); end
    endtask

    task automatic test_shifts();
        logic [31:0] expRes;
        logic        expWb;
        logic [4:0]  sU [3];
        logic [31:0] sA [3];
        logic [31:0] sB [3];
        int          lat;
        sU[0] = 5'd6;  sA[0] = 32'h8000_0001; sB[0] = 32'd1;
        sU[1] = 5'd11; sA[1] = 32'h8000_0000; sB[1] = 32'd40;
        sU[2] = 5'd7;  sA[2] = 32'h1234_5678; sB[2] = 32'h0000_0F00;
        model(5'd1, 32'hFFFF_FFFF, 32'd1, 1'b1, expRes, expWb);
        do_op(5'd1, 32'hFFFF_FFFF, 32'd1, 1'b1, lat);
        for (int i = 0; i < 3; i++) begin
            model(sU[i], sA[i], sB[i], 1'b1, expRes, expWb);
            do_op(sU[i], sA[i], sB[i], 1'b1, lat);
            compared++; if (out_result !== expRes) begin mismatched++; $display("[TB] FAIL shift%0d_result: got %h expected %h", i, out_result, expRes); end
            compared++; if (flags !== modelFlags) begin mismatched++; $display("[TB] FAIL shift%0d_flags: got %b expected %b", i, flags, modelFlags); end
            compared++; if (flags[1] !== 1'b1) begin mismatched++; $display("[TB] FAIL shift%0d_carry: got %b expected 1", i, flags[1]); end
        end
        compared++; if (out_result !== 32'h1234_5678) begin mismatched++; $display("[TB] FAIL lsr0_unchanged: got %h expected 12345678", out_result); end
    endtask

    task automatic test_mul();
        logic [31:0] expRes;
        logic        expWb;
        int          lat, viol;
        model(5'd12, 32'h0001_0000, 32'h0001_0000, 1'b1, expRes, expWb);
        uop = 5'd12; lhs = 32'h0001_0000; rhs = 32'h0001_0000; set_flags = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat  = 1;
        viol = 0;
        while (!out_valid && lat < 100) begin
            if (!busy || in_ready) viol++;
            @(posedge clk); #1;
            lat++;
        end
        compared++; if (lat !== 33) begin mismatched++; $display("[TB] FAIL mul_latency: got %0d expected 33", lat); end
        compared++; if (viol !== 0) begin mismatched++; $display("[TB] FAIL mul_busy_window: got %0d bad cycles expected 0", viol); end
        compared++; if (out_result !== expRes) begin mismatched++; $display("[TB] FAIL mul_result: got %h expected %h", out_result, expRes); end
        compared++; if (flags !== modelFlags) begin mismatched++; $display("[TB] FAIL mul_flags: got %b expected %b", flags, modelFlags); end
    endtask

    task automatic test_backpressure();
        logic [31:0] andRes, eorRes;
        logic        expWb;
        int          lat, viol;
        @(posedge clk); #1;
        out_ready = 1'b0;
        model(5'd3, 32'hF0F0_1234, 32'h0FF0_FF00, 1'b1, andRes, expWb);
        do_op(5'd3, 32'hF0F0_1234, 32'h0FF0_FF00, 1'b1, lat);
        model(5'd4, 32'hAAAA_5555, 32'h0000_FFFF, 1'b0, eorRes, expWb);
        uop = 5'd4; lhs = 32'hAAAA_5555; rhs = 32'h0000_FFFF; set_flags = 1'b0; in_valid = 1'b1;
        viol = 0;
        repeat (5) begin
            if (out_valid !== 1'b1 || out_result !== andRes || out_wb !== 1'b1 || in_ready !== 1'b0) viol++;
            @(posedge clk); #1;
        end
        compared++; if (viol !== 0) begin mismatched++; $display("[TB] FAIL bp_hold: got %0d bad cycles expected 0", viol); end
        compared++; if (out_result !== andRes) begin mismatched++; $display("[TB] FAIL bp_and_result: got %h expected %h", out_result, andRes); end
        out_ready = 1'b1;
        #1;
        compared++; if (in_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL bp_ready_rise: got %b expected 1", in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        compared++; if (out_valid !== 1'b1 || out_result !== eorRes) begin mismatched++; $display("[TB] FAIL bp_second_beat: got v=%b %h expected v=1 %h", out_valid, out_result, eorRes); end
        compared++; if (flags !== modelFlags) begin mismatched++; $display("[TB] FAIL bp_flags: got %b expected %b", flags, modelFlags); end
        @(posedge clk); #1;
        compared++; if (out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL bp_no_duplicate: got %b expected 0", out_valid); end
    endtask

    task automatic test_random();
        logic [31:0] expRes, a, b;
        logic [4:0]  u;
        logic        expWb, sf;
        int          lat;
        for (int i = 0; i < 200; i++) begin
            u  = 5'($urandom_range(0, 17));
            a  = $urandom;
            b  = $urandom;
            sf = 1'($urandom_range(0, 1));
            if ((u == 5'd6 || u == 5'd7 || u == 5'd11) && $urandom_range(0, 3) != 0)
                b = 32'($urandom_range(0, 40));
            if (u == 5'd12 && $urandom_range(0, 1) == 0)
                b = 32'($urandom_range(0, 300));
            model(u, a, b, sf, expRes, expWb);
            do_op(u, a, b, sf, lat);
            compared++; if (lat !== ((u == 5'd12) ? 33 : 1)) begin mismatched++; $display("[TB] FAIL rnd%0d_latency uop=%0d: got %0d", i, u, lat); end
            compared++; if (out_result !== expRes) begin mismatched++; $display("[TB] FAIL rnd%0d_result uop=%0d a=%h b=%h: got %h expected %h", i, u, a, b, out_result, expRes); end
            compared++; if (out_wb !== expWb) begin mismatched++; $display("[TB] FAIL rnd%0d_wb uop=%0d: got %b expected %b", i, u, out_wb, expWb); end
            compared++; if (flags !== modelFlags) begin mismatched++; $display("[TB] FAIL rnd%0d_flags uop=%0d a=%h b=%h: got %b expected %b", i, u, a, b, flags, modelFlags); end
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        modelFlags = 4'b0000;
        test_reset();
        test_reset_mid_mul();
        test_add_adc();
        test_cmp();
        test_shifts();
        test_mul();
        test_backpressure();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, handshaked, registered successor to the combinational execute-stage ALU.
- Sits between decode and writeback in the CPU datapath.
- Holds the architectural NZCV flag register internally.
- Adds carry-chained ops (ADC/SBC), ASR with shifter carry-out, per-op flag-set control, and an iterative multi-cycle MUL, all behind valid/ready so the pipeline can stall.

Parameters:
- WIDTH, 32, operand/result width in bits (>=8).
- SHAMT_W, 8, number of rhs low bits used as shift amount.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operation request valid.
- in_ready  out  1  block can accept a request this cycle.
- uop  in  5  micro-op code (encoding below).
- lhs  in  WIDTH  left operand.
- rhs  in  WIDTH  right operand / shift amount.
- set_flags  in  1  update NZCV on completion (CMP ignores this and always sets flags).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_result  out  WIDTH  registered result.
- out_wb  out  1  result is to be written to a register (0 for NOP, CMP).
- flags  out  4  registered {N,Z,C,V}.
- busy  out  1  multi-cycle op in progress.

Behaviour:
- Reset is asynchronous and active-low:
  - FSM to IDLE.
  - out_valid=0, out_result=0, out_wb=0, flags=4'b0000, busy=0.
  - Any in-flight MUL is discarded.
- Uop encoding:
  - NOP=0, ADD=1, SUB=2, AND=3, EOR=4, CMP=5, LSL=6, LSR=7, MOV=8, ADC=9, SBC=10, ASR=11, MUL=12, ADDR=13.
  - Codes 14–31 are treated as NOP.
- Handshake:
  - A request is accepted when in_valid && in_ready.
  - A result is consumed when out_valid && out_ready.
  - in_ready = (state==IDLE && (!out_valid || out_ready)).
  - out_result, out_wb and out_valid hold stable while out_valid && !out_ready.
- FSM states: IDLE, MUL_RUN.
  - IDLE, accept non-MUL: result registered at the next edge; out_valid=1 next cycle (latency 1). Back-to-back accepts are allowed at full rate when out_ready=1.
  - IDLE, accept MUL: go to MUL_RUN, busy=1, counter=WIDTH. Shift-add one multiplier bit per cycle.
  - MUL_RUN: in_ready=0. When the counter reaches 0, register the low WIDTH bits of the product, set out_valid=1, return to IDLE. Latency is WIDTH+1 cycles from accept to out_valid.
  - MUL_RUN does not complete while out_valid && !out_ready; it waits at counter=0.
- Arithmetic (all modulo 2^WIDTH; msb = bit WIDTH-1):
  - ADD/ADC: C = carry out. ADC adds the current flags.C.
  - SUB/CMP/SBC: computed as lhs + ~rhs + cin, with cin=1 for SUB/CMP and flags.C for SBC. C = carry out, i.e. 1 = no borrow.
  - V for add: operands share a sign and the result sign differs. V for sub: operand signs differ and the result sign differs from lhs.
  - AND/EOR/MOV: C and V unchanged.
  - LSL/LSR/ASR: amount s = rhs[SHAMT_W-1:0].
    - s=0: result=lhs, C unchanged.
    - 1<=s<=WIDTH: C = last bit shifted out.
    - s>WIDTH: result 0 (LSL/LSR) or all sign bits (ASR); C=0 (LSL/LSR) or lhs msb (ASR).
    - V unchanged.
  - MUL: N and Z updated; C and V unchanged.
  - ADDR: lhs+rhs, flags never change, out_wb=1.
- Flag update:
  - On the edge that registers a result, if (set_flags || uop==CMP) and uop not in {NOP, ADDR, invalid}: N=result msb, Z=(result==0), plus C/V as above.
  - set_flags is latched at accept for MUL.
  - ADC/SBC immediately following a flag-setting op see that op's flags (flags are registered before the next accept's compute).
- out_wb = 1 for all ops except NOP, CMP and invalid codes. NOP still produces an out_valid beat, with result 0.

Test Plan:
- Reset mid-MUL: accept MUL 7*9, assert rst_n=0 in cycle 3 -> immediately out_valid=0, flags=0, in_ready=1 after release; no result beat.
- ADD 0xFFFFFFFF+1 with set_flags=1 -> next cycle out_result=0, flags={N0,Z1,C1,V0}; then ADC 5+3 -> 9, out_wb=1.
- CMP 0x80000000 vs 1, set_flags=0 -> out_result=0x7FFFFFFF, out_wb=0, flags={N0,Z0,C1,V1}.
- Shifts, flags preset C=1, set_flags=1:
  - LSL 0x80000001 by 1 -> 0x00000002, C=1.
  - ASR 0x80000000 by 40 -> 0xFFFFFFFF, C=1.
  - LSR by 0 -> lhs unchanged, C stays 1.
- MUL 0x10000*0x10000 set_flags=1 -> out_valid exactly WIDTH+1=33 cycles after accept; out_result=0, Z=1, C/V unchanged; in_ready=0 and busy=1 throughout.
- Backpressure: out_ready=0 for 5 cycles after an AND result -> out_result/out_valid stable, in_ready=0; a second request is accepted only in the cycle out_ready rises; no beat lost or duplicated.
